// File: rtl/if_id_stage.sv
// IF/ID pipeline register with branch redirect tracking and saturating counters.
// A taken prediction turns the fall-through word held in the cycle after a branch into a bubble.
module if_id_stage #(
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_pc,
  input  logic [31:0] inst_mem_read_data,
  input  logic        IF_take,
  input  logic        EX_flush,
  input  logic        EX_MEM_stall,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc,
  output logic        ID_valid,
  output logic        ID_branch,
  output logic [31:0] ID_imme,
  output logic [4:0]  ID_rs1,
  output logic [4:0]  ID_rs2,
  output logic [4:0]  ID_rd,
  output logic [31:0] branch_count,
  output logic [31:0] flush_count,
  output logic [31:0] kill_count
);

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] CNT_MAX    = 32'hFFFFFFFF;

  typedef enum logic {
    NORMAL,
    REDIRECT
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] inst_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic        kill;
  logic        advance;

  assign advance = !EX_MEM_stall;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q  <= NOP_INST;
      pc_q    <= 32'd0;
      valid_q <= 1'b0;
    end else if (advance) begin
      pc_q <= IF_pc;
      if (EX_flush) begin
        inst_q  <= NOP_INST;
        valid_q <= 1'b0;
      end else begin
        inst_q  <= inst_mem_read_data;
        valid_q <= 1'b1;
      end
    end
  end

  // Wrong-path fall-through: held word right after a branch predicted taken.
  assign kill      = (state_q == REDIRECT) && IF_take;
  assign ID_valid  = valid_q && !kill;
  assign ID_inst   = ID_valid ? inst_q : NOP_INST;
  assign ID_pc     = pc_q;
  assign ID_branch = ID_valid && (inst_q[6:0] == OPC_BRANCH) && !EX_MEM_stall && !EX_flush;
  assign ID_imme   = {{20{ID_inst[31]}}, ID_inst[7], ID_inst[30:25], ID_inst[11:8], 1'b0};
  assign ID_rs1    = ID_inst[19:15];
  assign ID_rs2    = ID_inst[24:20];
  assign ID_rd     = ID_inst[11:7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= NORMAL;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (advance) begin
      if (EX_flush)       state_d = NORMAL;
      else if (ID_branch) state_d = REDIRECT;
      else                state_d = NORMAL;
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count <= 32'd0;
      flush_count  <= 32'd0;
      kill_count   <= 32'd0;
    end else begin
      if (ID_branch)           branch_count <= sat_inc(branch_count);
      if (EX_flush && advance) flush_count  <= sat_inc(flush_count);
      if (kill && advance)     kill_count   <= sat_inc(kill_count);
    end
  end

endmodule
